alu_sequencer: RTL
==================

# alu_sequencer

Multi-cycle control sequencer that drives the 8-bit ALU and register file of the lab CPU. It fetches a 32-bit instruction over a ready/request handshake, decodes it into ALU SELECT codes and register/immediate controls, and times the ALU latency. It then issues a single-cycle register write and computes the next PC, including jump and branch-if-equal targets from the ALU ZERO flag. It sits between instruction memory and the datapath, as the initiator whose commands the ALU executes.

## Interface
- REG_SIZE, 8, datapath/immediate width
- PC_WIDTH, 32, program counter width
- CLK  in  1  rising-edge clock
- RESET_N  in  1  asynchronous, active-low reset
- INSTR_REQ  out  1  fetch request to instruction memory
- INSTR_READY  in  1  instruction memory has INSTRUCTION valid
- INSTRUCTION  in  32  OP[31:24], RD/OFFSET[23:16], RT[15:8], RS/IMM[7:0]
- ZERO  in  1  ALU zero flag
- PC  out  PC_WIDTH  address of current instruction
- ALUOP  out  3  ALU SELECT: 000 fwd, 001 add, 010 and, 011 or, 100 mult, 101 logical shift, 110 arith shift
- READREG1 / READREG2 / WRITEREG  out  3 each  = INSTRUCTION[10:8] / [2:0] / [18:16]
- IMMEDIATE  out  REG_SIZE  = INSTRUCTION[7:0]
- IMM_SEL  out  1  DATA2 source: 1 immediate, 0 register
- NEG_SEL  out  1  DATA2 two's-complemented before the ALU
- WRITEENABLE  out  1  register-file write strobe
- ILLEGAL  out  1  sticky: undefined opcode seen

## Operation
- States: FETCH, DECODE, EXEC, WB.
- FETCH: INSTR_REQ=1. On an edge with INSTR_READY=1, latch INSTRUCTION and go to DECODE. INSTR_READY is ignored in all other states.
- DECODE: drive all decoded outputs from the latched instruction. Load the wait counter: 1 for ALUOP 000/010/011, 2 for 001/100/101/110. Go to EXEC.
- EXEC: decrement the counter. When it reaches 0, sample ZERO and go to WB.
- WB: WRITEENABLE=1 for exactly this cycle on register-writing ops. Update PC, then go to FETCH.
- Opcode decode, as ALUOP/IMM_SEL/NEG_SEL/writes:
  - 0x00 loadi: 000/1/0/yes
  - 0x01 mov: 000/0/0/yes
  - 0x02 add: 001/0/0/yes
  - 0x03 sub: 001/0/1/yes
  - 0x04 and: 010/0/0/yes
  - 0x05 or: 011/0/0/yes
  - 0x06 j: no ALU use, no write
  - 0x07 beq: 001/0/1/no
  - 0x08 mult: 100/0/0/yes
  - 0x09 sll: 101/1/0/yes
  - 0x0A srl: 101/1/1/yes
  - 0x0B sra: 110/1/1/yes
- Next PC:
  - Default is PC+4.
  - j: PC+4+(sext(OFFSET)<<2).
  - beq: the same target if sampled ZERO=1, else PC+4.
  - All arithmetic is modulo 2^PC_WIDTH, so wrap-around is allowed.
- Opcodes 0x0C-0xFF: set ILLEGAL, execute as a NOP (1 EXEC cycle, no write, PC+4). ILLEGAL clears only on reset.
- Decoded outputs hold their values from DECODE through WB and are not cleared in FETCH.

## Timing
- Reset (async assert, sync release):
  - Outputs: PC=0, ALUOP=000, all select/enable outputs 0, register addresses 0, IMMEDIATE=0, ILLEGAL=0.
  - State forced to FETCH, counter 0.
  - INSTR_REQ is 0 while RESET_N=0 and 1 in the first cycle after release.
- Per-instruction cycles, with INSTR_READY high on the first FETCH cycle:
  - 4 cycles for 1-cycle ALU ops, jumps and illegal opcodes.
  - 5 cycles for 2-cycle ALU ops and beq.
  - Each extra cycle INSTR_READY stays low adds one FETCH cycle.
- PC changes only on the WB→FETCH edge.
- WRITEENABLE is never asserted in two consecutive cycles.
- Reset asserted mid-EXEC or mid-WB aborts the instruction immediately: no write completes after assertion, and PC returns to 0.
- ZERO is sampled only on the final EXEC edge. Glitches earlier in EXEC are ignored.

## Test plan
- Reset release, INSTR_READY=1 always, loadi r2,#0x05 (0x00020005) -> FETCH at cycle 1; ALUOP=000, IMM_SEL=1, WRITEREG=2; WRITEENABLE high in cycle 4 only; PC=4 after.
- add r1,r2,r3 (0x02010203) -> ALUOP=001, READREG1=2, READREG2=3, two EXEC cycles; WRITEENABLE in cycle 5; PC 4→8.
- beq OFFSET=0xFE at PC=0x10: ZERO=1 -> PC=0x0C, NEG_SEL=1, no write; ZERO=0 -> PC=0x14.
- INSTR_READY held low 3 cycles at PC=0xFFFFFFFC with j OFFSET=0x00 -> INSTR_REQ high 4 cycles; PC wraps to 0x00000000.
- Opcode 0x3F -> ILLEGAL=1, no WRITEENABLE, PC+4; ILLEGAL stays high through a following valid add.
- RESET_N pulsed low during EXEC of mult -> WRITEENABLE never asserts, PC=0, ILLEGAL=0, INSTR_REQ=1 after release.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-cycle control sequencer for the lab CPU: fetches a 32-bit instruction,
// decodes it into ALU/register-file controls, times the ALU latency, writes back and advances the PC.
module alu_sequencer #(
    parameter int REG_SIZE = 8,
    parameter int PC_WIDTH = 32
) (
    input  logic                CLK,
    input  logic                RESET_N,
    output logic                INSTR_REQ,
    input  logic                INSTR_READY,
    input  logic [31:0]         INSTRUCTION,
    input  logic                ZERO,
    output logic [PC_WIDTH-1:0] PC,
    output logic [2:0]          ALUOP,
    output logic [2:0]          READREG1,
    output logic [2:0]          READREG2,
    output logic [2:0]          WRITEREG,
    output logic [REG_SIZE-1:0] IMMEDIATE,
    output logic                IMM_SEL,
    output logic                NEG_SEL,
    output logic                WRITEENABLE,
    output logic                ILLEGAL
);

    typedef enum logic [1:0] {FETCH, DECODE, EXEC, WB} state_t;

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [2:0]            aluop_q, aluop_d;
    logic [2:0]            rr1_q, rr1_d, rr2_q, rr2_d, wreg_q, wreg_d;
    logic [REG_SIZE-1:0]   imm_q, imm_d;
    logic                  imm_sel_q, imm_sel_d, neg_sel_q, neg_sel_d;
    logic                  wr_q, wr_d, is_j_q, is_j_d, is_beq_q, is_beq_d;
    logic [7:0]            off_q, off_d;
    logic                  zero_q, zero_d;
    logic                  illegal_q, illegal_d;

    logic [2:0]            dec_aluop;
    logic                  dec_imm, dec_neg, dec_wr, dec_j, dec_beq, dec_ill;
    logic                  take;
    logic [PC_WIDTH-1:0]   branch_off;
    logic                  unused_instr;

    assign unused_instr = ^INSTRUCTION[15:11];

    // Opcode decode straight off the memory bus; captured on the accepting FETCH edge.
    always_comb begin
        dec_aluop = 3'b000;
        dec_imm   = 1'b0;
        dec_neg   = 1'b0;
        dec_wr    = 1'b0;
        dec_j     = 1'b0;
        dec_beq   = 1'b0;
        dec_ill   = 1'b0;
        case (INSTRUCTION[31:24])
            8'h00: begin dec_imm = 1'b1; dec_wr = 1'b1; end
            8'h01: dec_wr = 1'b1;
            8'h02: begin dec_aluop = 3'b001; dec_wr = 1'b1; end
            8'h03: begin dec_aluop = 3'b001; dec_neg = 1'b1; dec_wr = 1'b1; end
            8'h04: begin dec_aluop = 3'b010; dec_wr = 1'b1; end
            8'h05: begin dec_aluop = 3'b011; dec_wr = 1'b1; end
            8'h06: dec_j = 1'b1;
            8'h07: begin dec_aluop = 3'b001; dec_neg = 1'b1; dec_beq = 1'b1; end
            8'h08: begin dec_aluop = 3'b100; dec_wr = 1'b1; end
            8'h09: begin dec_aluop = 3'b101; dec_imm = 1'b1; dec_wr = 1'b1; end
            8'h0A: begin dec_aluop = 3'b101; dec_imm = 1'b1; dec_neg = 1'b1; dec_wr = 1'b1; end
            8'h0B: begin dec_aluop = 3'b110; dec_imm = 1'b1; dec_neg = 1'b1; dec_wr = 1'b1; end
            default: dec_ill = 1'b1;
        endcase
    end

    assign take       = is_j_q | (is_beq_q & zero_q);
    assign branch_off = {{(PC_WIDTH-10){off_q[7]}}, off_q, 2'b00};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_d      = pc_q;
        aluop_d   = aluop_q;
        rr1_d     = rr1_q;
        rr2_d     = rr2_q;
        wreg_d    = wreg_q;
        imm_d     = imm_q;
        imm_sel_d = imm_sel_q;
        neg_sel_d = neg_sel_q;
        wr_d      = wr_q;
        is_j_d    = is_j_q;
        is_beq_d  = is_beq_q;
        off_d     = off_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            FETCH: begin
                if (INSTR_READY) begin
                    aluop_d   = dec_aluop;
                    rr1_d     = INSTRUCTION[10:8];
                    rr2_d     = INSTRUCTION[2:0];
                    wreg_d    = INSTRUCTION[18:16];
                    imm_d     = INSTRUCTION[REG_SIZE-1:0];
                    imm_sel_d = dec_imm;
                    neg_sel_d = dec_neg;
                    wr_d      = dec_wr;
                    is_j_d    = dec_j;
                    is_beq_d  = dec_beq;
                    off_d     = INSTRUCTION[23:16];
                    illegal_d = illegal_q | dec_ill;
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                // add/sub/beq, mult and shifts need two ALU cycles; everything else one.
                cnt_d   = (aluop_q == 3'b001 || aluop_q == 3'b100 ||
                           aluop_q == 3'b101 || aluop_q == 3'b110) ? 2'd2 : 2'd1;
                state_d = EXEC;
            end
            EXEC: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    zero_d  = ZERO;
                    state_d = WB;
                end
            end
            WB: begin
                pc_d    = pc_q + PC_WIDTH'(4) + (take ? branch_off : '0);
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= FETCH;
            cnt_q     <= '0;
            pc_q      <= '0;
            aluop_q   <= '0;
            rr1_q     <= '0;
            rr2_q     <= '0;
            wreg_q    <= '0;
            imm_q     <= '0;
            imm_sel_q <= 1'b0;
            neg_sel_q <= 1'b0;
            wr_q      <= 1'b0;
            is_j_q    <= 1'b0;
            is_beq_q  <= 1'b0;
            off_q     <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pc_q      <= pc_d;
            aluop_q   <= aluop_d;
            rr1_q     <= rr1_d;
            rr2_q     <= rr2_d;
            wreg_q    <= wreg_d;
            imm_q     <= imm_d;
            imm_sel_q <= imm_sel_d;
            neg_sel_q <= neg_sel_d;
            wr_q      <= wr_d;
            is_j_q    <= is_j_d;
            is_beq_q  <= is_beq_d;
            off_q     <= off_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    // Request is masked by reset because the state register already sits in FETCH while held.
    assign INSTR_REQ   = (state_q == FETCH) && RESET_N;
    assign WRITEENABLE = (state_q == WB) && wr_q;
    assign PC          = pc_q;
    assign ALUOP       = aluop_q;
    assign READREG1    = rr1_q;
    assign READREG2    = rr2_q;
    assign WRITEREG    = wreg_q;
    assign IMMEDIATE   = imm_q;
    assign IMM_SEL     = imm_sel_q;
    assign NEG_SEL     = neg_sel_q;
    assign ILLEGAL     = illegal_q;

endmodule
